// File: rtl/i2c_pkg.sv
// Shared types and defaults for the i2c_master arbiter.
package i2c_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      RESPOND
   } arb_state_t;

   typedef enum logic [1:0] {
      OK       = 2'd0,
      START_TO = 2'd1,
      XFER_TO  = 2'd2
   } i2c_err_t;

   localparam int DEF_START_TIMEOUT = 1023;
   localparam int DEF_XFER_TIMEOUT  = 65535;
   localparam int WD_W              = 16;

endpackage

// File: rtl/i2c_arbiter_rr.sv
// Combinational round-robin picker: searches from the index after last_grant.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_grant,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);

   logic          found;
   logic [IW-1:0] idx;
   int            pos;

   assign any = |req;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      pos       = 0;
      for (int k = 1; k <= N; k++) begin
         pos = (int'(last_grant) + k) % N;
         idx = IW'(pos);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters: round-robin grant,
// command latch, busy synchronizer, start/transfer watchdog, response regs.
module i2c_arbiter
   import i2c_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT,
   parameter int XFER_TIMEOUT  = DEF_XFER_TIMEOUT
) (
   input  logic                    sysclk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ-1:0]      req_rw,
   input  logic [NUM_REQ-1:0][6:0] req_addr,
   input  logic [NUM_REQ-1:0][7:0] req_wdata,
   output logic [NUM_REQ-1:0]      req_ack,
   output logic [NUM_REQ-1:0]      done,
   output logic [7:0]              rdata,
   output logic [1:0]              err,
   output logic                    m_enable,
   output logic                    m_rw,
   output logic [6:0]              m_address,
   output logic [7:0]              m_wdata,
   input  logic [7:0]              m_rdata,
   input  logic                    m_busy
);

   localparam int             IW        = $clog2(NUM_REQ);
   localparam logic [WD_W-1:0] START_LIM = WD_W'(START_TIMEOUT);
   localparam logic [WD_W-1:0] XFER_LIM  = WD_W'(XFER_TIMEOUT);

   arb_state_t          state, state_nxt;
   logic                busy_s1, busy_s2;
   logic [WD_W-1:0]     wd;
   logic [IW-1:0]       last_grant, last_grant_nxt;
   i2c_err_t            err_q, err_nxt;

   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       grant_idx;
   logic                any_req;

   logic [NUM_REQ-1:0]  req_ack_nxt, done_nxt;
   logic [7:0]          rdata_nxt, m_wdata_nxt;
   logic [6:0]          m_address_nxt;
   logic                m_enable_nxt, m_rw_nxt;
   logic                start_to, xfer_to;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
      .req        (req),
      .last_grant (last_grant),
      .grant      (grant),
      .grant_idx  (grant_idx),
      .any        (any_req)
   );

   assign start_to = (wd >= START_LIM);
   assign xfer_to  = (wd >= XFER_LIM);
   assign err      = err_q;

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (any_req) state_nxt = ISSUE;
         ISSUE:     if (busy_s2) state_nxt = WAIT_DONE;
                    else if (start_to) state_nxt = RESPOND;
         WAIT_DONE: if (!busy_s2 || xfer_to) state_nxt = RESPOND;
         RESPOND:   state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Outputs are registered; these are their next values. Completion wins
   // over a timeout that fires in the same cycle.
   always_comb begin
      req_ack_nxt    = '0;
      done_nxt       = '0;
      m_enable_nxt   = m_enable;
      m_rw_nxt       = m_rw;
      m_address_nxt  = m_address;
      m_wdata_nxt    = m_wdata;
      rdata_nxt      = rdata;
      err_nxt        = err_q;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (any_req) begin
               req_ack_nxt    = grant;
               m_enable_nxt   = 1'b1;
               m_rw_nxt       = req_rw[grant_idx];
               m_address_nxt  = req_addr[grant_idx];
               m_wdata_nxt    = req_wdata[grant_idx];
               last_grant_nxt = grant_idx;
            end
         end
         ISSUE: begin
            if (busy_s2) begin
               m_enable_nxt = 1'b0;
            end else if (start_to) begin
               m_enable_nxt = 1'b0;
               err_nxt      = START_TO;
            end
         end
         WAIT_DONE: begin
            if (!busy_s2) begin
               err_nxt = OK;
               if (m_rw) rdata_nxt = m_rdata;
            end else if (xfer_to) begin
               err_nxt = XFER_TO;
            end
         end
         RESPOND:  done_nxt[last_grant] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge sysclk or negedge reset_n) begin
      if (!reset_n) begin
         busy_s1    <= 1'b0;
         busy_s2    <= 1'b0;
         wd         <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         err_q      <= OK;
         req_ack    <= '0;
         done       <= '0;
         rdata      <= '0;
         m_enable   <= 1'b0;
         m_rw       <= 1'b0;
         m_address  <= '0;
         m_wdata    <= '0;
      end else begin
         busy_s1    <= m_busy;
         busy_s2    <= busy_s1;
         if (state_nxt != state) wd <= '0;
         else if (wd != '1)      wd <= wd + 1'b1;
         last_grant <= last_grant_nxt;
         err_q      <= err_nxt;
         req_ack    <= req_ack_nxt;
         done       <= done_nxt;
         rdata      <= rdata_nxt;
         m_enable   <= m_enable_nxt;
         m_rw       <= m_rw_nxt;
         m_address  <= m_address_nxt;
         m_wdata    <= m_wdata_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed + randomized bench for i2c_arbiter with a round-robin reference model
// and a behavioural i2c_master busy/rdata model.
module tb_i2c_arbiter;

   localparam int N  = 4;
   localparam int ST = 1023;
   localparam int XT = 65535;

   logic                sysclk = 1'b0;
   logic                reset_n;
   logic [N-1:0]        req, req_rw;
   logic [N-1:0][6:0]   req_addr;
   logic [N-1:0][7:0]   req_wdata;
   logic [N-1:0]        req_ack, done;
   logic [7:0]          rdata, m_wdata, m_rdata;
   logic [1:0]          err;
   logic                m_enable, m_rw, m_busy;
   logic [6:0]          m_address;

   int                  errors = 0;
   int                  checks = 0;
   int                  last_m;
   logic [7:0]          rdata_m;
   logic [N-1:0]        hold;
   int                  grants[$];

   i2c_arbiter #(.NUM_REQ(N), .START_TIMEOUT(ST), .XFER_TIMEOUT(XT)) dut (
      .sysclk    (sysclk),
      .reset_n   (reset_n),
      .req       (req),
      .req_rw    (req_rw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ack   (req_ack),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .m_enable  (m_enable),
      .m_rw      (m_rw),
      .m_address (m_address),
      .m_wdata   (m_wdata),
      .m_rdata   (m_rdata),
      .m_busy    (m_busy)
   );

   always #5 sysclk = ~sysclk;

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic tick();
      @(posedge sysclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: first pending requester after the previous winner, wrapping.
   function automatic int rr_pick(input logic [N-1:0] r, input int last);
      for (int k = 1; k <= N; k++)
         if (r[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_a"}, {req_ack, done, rdata, err}, 32'h0);
      chk({tag, "_b"}, {m_enable, m_rw, m_address, m_wdata}, 32'h0);
   endtask

   // mode 0: normal master, 1: master never starts, 2: master stalls forever
   task automatic txn(input int mode, input int blen, input logic [7:0] rd);
      int w, n;
      logic       rw_e;
      logic [6:0] ad_e;
      logic [7:0] wd_e;
      w = rr_pick(req, last_m);
      n = 0;
      while (req_ack == '0 && n < 20) begin tick(); n++; end
      chk("req_ack", req_ack, 32'(1) << w);
      if (req_ack == '0) begin req = '0; return; end
      grants.push_back(w);
      rw_e = req_rw[w]; ad_e = req_addr[w]; wd_e = req_wdata[w];
      chk("cmd_at_ack", {m_enable, m_rw, m_address, m_wdata}, {1'b1, rw_e, ad_e, wd_e});
      last_m = w;
      if (!hold[w]) req[w] = 1'b0;
      tick();
      chk("ack_pulse", req_ack, 0);
      case (mode)
         0: begin
            tick(); tick();
            m_busy = 1'b1;
            tick(); tick();
            chk("enable_held", m_enable, 1);
            tick();
            chk("enable_drop", m_enable, 0);
            repeat (blen) tick();
            chk("cmd_stable", {m_rw, m_address, m_wdata, done}, {rw_e, ad_e, wd_e, 4'h0});
            m_rdata = rd;
            m_busy  = 1'b0;
            tick(); tick(); tick();
            chk("done_early", done, 0);
            tick();
            if (rw_e) rdata_m = rd;
            chk("done", done, 32'(1) << w);
            chk("err_ok", err, 0);
            chk("rdata", rdata, rdata_m);
         end
         1: begin
            n = 0;
            while (done == '0 && n < ST + 20) begin tick(); n++; end
            chk("start_to_latency", (n >= ST - 1 && n <= ST + 3), 1);
            chk("start_to_done", done, 32'(1) << w);
            chk("start_to_err", {m_enable, err}, 3'b001);
            chk("start_to_rdata", rdata, rdata_m);
         end
         default: begin
            tick(); tick();
            m_busy = 1'b1;
            n = 0;
            while (m_enable && n < 10) begin tick(); n++; end
            chk("stall_enable_drop", m_enable, 0);
            n = 0;
            while (done == '0 && n < XT + 20) begin tick(); n++; end
            chk("xfer_to_latency", (n >= XT && n <= XT + 4), 1);
            chk("xfer_to_done", done, 32'(1) << w);
            chk("xfer_to_err", err, 2);
            chk("xfer_to_rdata", rdata, rdata_m);
            m_busy = 1'b0;
         end
      endcase
      tick();
      chk("done_pulse", done, 0);
   endtask

   initial begin
      int dseen;
      reset_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      m_busy = 1'b0; m_rdata = '0; hold = '0; last_m = N - 1; rdata_m = '0;
      repeat (3) tick();
      chk_quiet("reset_state");
      reset_n = 1'b1;
      tick(); tick();
      chk_quiet("idle_after_reset");

      // Fairness: everyone holds req; order must rotate 0,1,2,3,0
      for (int k = 0; k < N; k++) begin
         req_rw[k] = 1'($urandom); req_addr[k] = 7'($urandom); req_wdata[k] = 8'($urandom);
      end
      hold = '1; req = '1;
      for (int k = 0; k < 4; k++) txn(0, $urandom_range(2, 10), 8'($urandom));
      hold = '0;
      txn(0, 5, 8'($urandom));
      for (int k = 0; k < 5; k++)
         chk("rr_order", (grants.size() > k) ? grants[k] : -1, k % N);
      while (req != '0) txn(0, 4, 8'($urandom));

      // Single write then single read
      req_rw[1] = 1'b0; req_addr[1] = 7'h50; req_wdata[1] = 8'hA5; req[1] = 1'b1;
      txn(0, 97, 8'hEE);
      req_rw[2] = 1'b1; req_addr[2] = 7'h1D; req_wdata[2] = 8'h00; req[2] = 1'b1;
      txn(0, 97, 8'h3C);
      chk("read_byte", rdata, 8'h3C);

      // Randomized mixes of pending requesters
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < N; k++) begin
            req_rw[k] = 1'($urandom); req_addr[k] = 7'($urandom); req_wdata[k] = 8'($urandom);
         end
         req = N'($urandom_range(1, (1 << N) - 1));
         while (req != '0) txn(0, $urandom_range(2, 20), 8'($urandom));
      end

      req[0] = 1'b1;
      txn(1, 0, 8'h00);
      req[1] = 1'b1;
      txn(2, 0, 8'h00);
      repeat (4) tick();

      // Reset in the middle of a transfer
      req_rw[0] = 1'b1; req[0] = 1'b1;
      dseen = 0;
      for (int n = 0; n < 20 && req_ack == '0; n++) tick();
      chk("rst_txn_ack", req_ack, 1);
      req[0] = 1'b0;
      tick(); tick();
      m_busy = 1'b1; m_rdata = 8'h99;
      repeat (8) tick();
      #2 reset_n = 1'b0;
      #1 chk_quiet("async_reset");
      m_busy = 1'b0;
      for (int n = 0; n < 3; n++) begin tick(); if (done != '0) dseen++; end
      reset_n = 1'b1;
      last_m = N - 1; rdata_m = '0;
      for (int n = 0; n < 6; n++) begin tick(); if (done != '0) dseen++; end
      chk("no_done_after_abort", dseen, 0);
      chk_quiet("idle_after_abort");
      req_rw[3] = 1'b1; req_addr[3] = 7'h2A; req_wdata[3] = 8'h11; req[3] = 1'b1;
      txn(0, 10, 8'h77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
